// File: rtl/bus_src_mux_reg_pkg.sv
// Processor-wide bus-source constants: opcode values, select encoding, default width.
package bus_src_mux_reg_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  localparam logic [2:0] OP_MV  = 3'b000;  // sign-extended immediate
  localparam logic [2:0] OP_MVT = 3'b001;  // move-to-top immediate

  // Select encoding: registers occupy REG0..REG0+NUM_REGS-1, then immediate, then din.
  localparam int SEL_REG0 = 0;

  function automatic int sel_imm(input int num_regs);
    return SEL_REG0 + num_regs;
  endfunction

  function automatic int sel_din(input int num_regs);
    return SEL_REG0 + num_regs + 1;
  endfunction

endpackage

// File: rtl/bus_src_mux_reg_imm_format.sv
// Combinational immediate formatter: turns the instruction register into a bus-width immediate.
module bus_src_mux_reg_imm_format #(
  parameter int                DATA_W = 16,
  parameter int                IMM_SW = 9,
  parameter int                OP_W   = 3,
  parameter logic [OP_W-1:0]   OP_MV  = 3'b000,
  parameter logic [OP_W-1:0]   OP_MVT = 3'b001
) (
  input  logic [DATA_W-1:0] ir_in,
  output logic [DATA_W-1:0] imm_out
);

  localparam int H = DATA_W / 2;

  logic [OP_W-1:0] op;
  // Middle instruction bits are not part of any immediate form.
  logic            unused_ir;

  assign op        = ir_in[DATA_W-1 -: OP_W];
  assign unused_ir = ^ir_in;

  // Opcode picks sign-extend, move-to-top, or plain zero-extend of the low half.
  always_comb begin
    imm_out = {{(DATA_W-H){1'b0}}, ir_in[H-1:0]};
    if (op == OP_MV) begin
      imm_out = {{(DATA_W-IMM_SW){ir_in[IMM_SW-1]}}, ir_in[IMM_SW-1:0]};
    end else if (op == OP_MVT) begin
      imm_out = {ir_in[H-1:0], {H{1'b0}}};
    end
  end

endmodule

// File: rtl/bus_src_mux_reg.sv
// Registered bus-source multiplexer with a one-deep valid/ready output stage
// and a sticky flag for out-of-range selects.
module bus_src_mux_reg #(
  parameter int              DATA_W   = bus_src_mux_reg_pkg::DATA_W,
  parameter int              NUM_REGS = 8,
  parameter int              SEL_W    = 4,
  parameter int              IMM_SW   = 9,
  parameter int              OP_W     = bus_src_mux_reg_pkg::OP_W,
  parameter logic [OP_W-1:0] OP_MV    = bus_src_mux_reg_pkg::OP_MV,
  parameter logic [OP_W-1:0] OP_MVT   = bus_src_mux_reg_pkg::OP_MVT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  input  logic [DATA_W-1:0]          ir_in,
  input  logic [DATA_W-1:0]          din,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       sel_valid,
  output logic                       sel_ready,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic                       illegal_sel,
  input  logic                       illegal_clr
);

  import bus_src_mux_reg_pkg::*;

  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(sel_imm(NUM_REGS));
  localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(sel_din(NUM_REGS));

  // Handshake: a select is accepted on a rising edge where sel_valid && sel_ready;
  // the consumer takes bus_out on a rising edge where bus_valid && bus_ready.
  // sel_ready = !bus_valid || bus_ready, so the stage refills in the same cycle it
  // is drained, and while stalled the select and sources are simply not sampled.
  logic              accept;
  logic              take;
  logic [DATA_W-1:0] imm_val;
  logic [DATA_W-1:0] dec_val;
  logic              dec_illegal;

  assign sel_ready = !bus_valid || bus_ready;
  assign accept    = sel_valid && sel_ready;
  assign take      = bus_valid && bus_ready;

  bus_src_mux_reg_imm_format #(
    .DATA_W (DATA_W),
    .IMM_SW (IMM_SW),
    .OP_W   (OP_W),
    .OP_MV  (OP_MV),
    .OP_MVT (OP_MVT)
  ) u_imm_format (
    .ir_in   (ir_in),
    .imm_out (imm_val)
  );

  // Decode the select into a source value; anything unmapped is illegal and yields zero.
  always_comb begin
    dec_val     = '0;
    dec_illegal = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sel == SEL_W'(SEL_REG0 + k)) begin
        dec_val     = reg_in[k*DATA_W +: DATA_W];
        dec_illegal = 1'b0;
      end
    end
    if (sel == SEL_IMM) begin
      dec_val     = imm_val;
      dec_illegal = 1'b0;
    end
    if (sel == SEL_DIN) begin
      dec_val     = din;
      dec_illegal = 1'b0;
    end
  end

  // Output register: load on accept, empty on a take with no refill, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else if (accept) begin
      bus_out   <= dec_val;
      bus_valid <= 1'b1;
    end else if (take) begin
      bus_valid <= 1'b0;
    end
  end

  // Sticky illegal flag; a new illegal accept wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      illegal_sel <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_sel <= 1'b1;
    end else if (illegal_clr) begin
      illegal_sel <= 1'b0;
    end
  end

endmodule
